// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares the single physical-memory port between the ICache and DCache miss
// paths. The winning request is latched in IDLE and replayed unchanged on the
// memory port until mem_resp, which is then routed to the winner.
// Optional build macro: ARB_DCACHE_PRIORITY_EN (DCache wins every tie instead
// of alternating round-robin).
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant_d;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_read;
  logic              lat_write;

  logic              i_req;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;

  // Pick the requester that would be granted if the arbiter is idle now
  always_comb begin
    i_req   = i_pmem_read;
    d_req   = d_pmem_read | d_pmem_write;
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (i_req && d_req) begin
`ifdef ARB_DCACHE_PRIORITY_EN
      grant_d = 1'b1;
`else
      grant_i = last_grant_d;
      grant_d = ~last_grant_d;
`endif
    end else begin
      grant_i = i_req;
      grant_d = d_req;
    end
  end

  // Arbitration FSM: latch the winning command, hold it until mem_resp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_read     <= 1'b0;
      lat_write    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i) begin
            state        <= SERVE_I;
            last_grant_d <= 1'b0;
            lat_addr     <= i_pmem_address;
            lat_wdata    <= '0;
            lat_read     <= 1'b1;
            lat_write    <= 1'b0;
          end else if (grant_d) begin
            state        <= SERVE_D;
            last_grant_d <= 1'b1;
            lat_addr     <= d_pmem_address;
            lat_wdata    <= d_pmem_wdata;
            lat_read     <= d_pmem_read & ~d_pmem_write;
            lat_write    <= d_pmem_write;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state     <= IDLE;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          lat_read  <= 1'b0;
          lat_write <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address  = lat_addr;
  assign mem_wdata    = lat_wdata;
  assign mem_read     = lat_read;
  assign mem_write    = lat_write;

  assign i_pmem_resp  = (state == SERVE_I) & mem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & mem_resp;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Directed scenarios followed by a randomized run against a transaction-level
// reference model of the arbiter. Honours ARB_DCACHE_PRIORITY_EN.
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

`ifdef ARB_DCACHE_PRIORITY_EN
  localparam bit D_PRIORITY = 1'b1;
`else
  localparam bit D_PRIORITY = 1'b0;
`endif

  typedef logic [LINE_W-1:0] val_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] i_pmem_address;
  logic              i_pmem_read;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic [ADDR_W-1:0] d_pmem_address;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_pmem_address (i_pmem_address),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_address (d_pmem_address),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_address    (mem_address),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  int check_count = 0;
  int pass_count  = 0;

  // Reference-model bookkeeping: which side was served last (1 = DCache)
  bit tb_last_d;

  // Random-phase model and agent state
  bit                m_busy, m_owner_d, m_rd, m_wr, m_last_d, pick_d;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  bit                i_act, d_act, d_rd_r, d_wr_r;
  logic [ADDR_W-1:0] i_addr_r, d_addr_r;
  logic [LINE_W-1:0] d_wdata_r, rnd_rdata;
  bit                mem_pend, resp_now, got_i, got_d;
  int                mem_wait;
  int                pulse_count;

  task automatic checkOutput(input string tag, input val_t observed, input val_t expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Drive all inputs just after a rising edge, then let combinational paths settle
  task automatic applyStimulus(input logic ird, input logic [ADDR_W-1:0] iaddr,
                               input logic drd, input logic dwr,
                               input logic [ADDR_W-1:0] daddr, input logic [LINE_W-1:0] dwdata,
                               input logic mresp, input logic [LINE_W-1:0] mrdata);
    i_pmem_read    = ird;
    i_pmem_address = iaddr;
    d_pmem_read    = drd;
    d_pmem_write   = dwr;
    d_pmem_address = daddr;
    d_pmem_wdata   = dwdata;
    mem_resp       = mresp;
    mem_rdata      = mrdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    tick();
    tick();
    rst_n = 1'b1;
    tb_last_d = 1'b1;
    tick();
  endtask

  // Both caches request together; winner is served, one idle cycle, then loser
  task automatic runTie(input string tag);
    bit d_first;
    logic [ADDR_W-1:0] first_addr, second_addr;
    d_first     = D_PRIORITY ? 1'b1 : !tb_last_d;
    first_addr  = d_first ? 16'h2222 : 16'h1111;
    second_addr = d_first ? 16'h1111 : 16'h2222;
    applyStimulus(1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, '0, 1'b0, '0);
    tick();
    checkOutput({tag, "_first_addr"}, val_t'(mem_address), val_t'(first_addr));
    checkOutput({tag, "_first_read"}, val_t'(mem_read), val_t'(1'b1));
    applyStimulus(1'b1, 16'h1111, 1'b1, 1'b0, 16'h2222, '0, 1'b1, 128'h11);
    checkOutput({tag, "_first_i_resp"}, val_t'(i_pmem_resp), val_t'(!d_first));
    checkOutput({tag, "_first_d_resp"}, val_t'(d_pmem_resp), val_t'(d_first));
    tick();
    checkOutput({tag, "_gap_read"}, val_t'(mem_read), val_t'(1'b0));
    applyStimulus(d_first, 16'h1111, !d_first, 1'b0, 16'h2222, '0, 1'b0, '0);
    tick();
    checkOutput({tag, "_second_addr"}, val_t'(mem_address), val_t'(second_addr));
    checkOutput({tag, "_second_read"}, val_t'(mem_read), val_t'(1'b1));
    applyStimulus(d_first, 16'h1111, !d_first, 1'b0, 16'h2222, '0, 1'b1, 128'h22);
    checkOutput({tag, "_second_i_resp"}, val_t'(i_pmem_resp), val_t'(d_first));
    checkOutput({tag, "_second_d_resp"}, val_t'(d_pmem_resp), val_t'(!d_first));
    tick();
    clearInputs();
    tb_last_d = !d_first;
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    tick();
    tick();
    checkOutput("rst_mem_read", val_t'(mem_read), val_t'(1'b0));
    checkOutput("rst_mem_write", val_t'(mem_write), val_t'(1'b0));
    checkOutput("rst_mem_address", val_t'(mem_address), val_t'(16'h0));
    checkOutput("rst_mem_wdata", mem_wdata, '0);
    checkOutput("rst_i_resp", val_t'(i_pmem_resp), val_t'(1'b0));
    checkOutput("rst_d_resp", val_t'(d_pmem_resp), val_t'(1'b0));
    rst_n = 1'b1;
    tb_last_d = 1'b1;
    tick();

    // ICache read, one-cycle latency, response routed back to I only
    applyStimulus(1'b1, 16'h1230, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    tick();
    checkOutput("i_read_mem_read", val_t'(mem_read), val_t'(1'b1));
    checkOutput("i_read_mem_write", val_t'(mem_write), val_t'(1'b0));
    checkOutput("i_read_addr", val_t'(mem_address), val_t'(16'h1230));
    applyStimulus(1'b1, 16'h1230, 1'b0, 1'b0, '0, '0, 1'b1, 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF);
    checkOutput("i_read_resp", val_t'(i_pmem_resp), val_t'(1'b1));
    checkOutput("i_read_rdata", i_pmem_rdata, 128'hDEADBEEF_01234567_89ABCDEF_DEADBEEF);
    checkOutput("i_read_d_resp", val_t'(d_pmem_resp), val_t'(1'b0));
    tick();
    clearInputs();
    checkOutput("i_read_done", val_t'(mem_read), val_t'(1'b0));
    tb_last_d = 1'b0;

    // DCache write-back held for 10 cycles; request dropped and altered mid-serve
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'h4000, {16{8'hA5}}, 1'b0, '0);
    tick();
    pulse_count = 0;
    for (int k = 0; k < 10; k++) begin
      checkOutput("dwr_mem_write", val_t'(mem_write), val_t'(1'b1));
      checkOutput("dwr_mem_read", val_t'(mem_read), val_t'(1'b0));
      checkOutput("dwr_addr", val_t'(mem_address), val_t'(16'h4000));
      checkOutput("dwr_wdata", mem_wdata, {16{8'hA5}});
      if (d_pmem_resp) pulse_count++;
      if (k == 3) applyStimulus(1'b0, '0, 1'b0, 1'b0, 16'h7777, '0, 1'b0, '0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 16'h7777, '0, 1'b1, 128'h5);
    checkOutput("dwr_d_resp", val_t'(d_pmem_resp), val_t'(1'b1));
    checkOutput("dwr_i_resp", val_t'(i_pmem_resp), val_t'(1'b0));
    if (d_pmem_resp) pulse_count++;
    tick();
    clearInputs();
    checkOutput("dwr_done", val_t'(mem_write), val_t'(1'b0));
    for (int k = 0; k < 3; k++) begin
      if (d_pmem_resp) pulse_count++;
      tick();
    end
    checkOutput("dwr_pulse_count", val_t'(pulse_count), val_t'(1));
    tb_last_d = 1'b1;

    // Ties after reset, then a tie after an I-only transaction
    doReset();
    runTie("tie1");

    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    tick();
    applyStimulus(1'b0, 16'h9999, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    tick();
    checkOutput("latched_addr", val_t'(mem_address), val_t'(16'h5555));
    checkOutput("latched_read", val_t'(mem_read), val_t'(1'b1));
    applyStimulus(1'b0, 16'h9999, 1'b0, 1'b0, '0, '0, 1'b1, 128'h77);
    checkOutput("dropped_req_resp", val_t'(i_pmem_resp), val_t'(1'b1));
    tick();
    clearInputs();
    tb_last_d = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1, 128'h99);
    checkOutput("idle_resp_i", val_t'(i_pmem_resp), val_t'(1'b0));
    checkOutput("idle_resp_d", val_t'(d_pmem_resp), val_t'(1'b0));
    tick();
    clearInputs();
    checkOutput("idle_resp_no_grant", val_t'(mem_read | mem_write), val_t'(1'b0));
    runTie("tie2");

    // Asynchronous reset in the middle of a DCache write
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 16'h6000, {16{8'h3C}}, 1'b0, '0);
    tick();
    checkOutput("mid_rst_pre_write", val_t'(mem_write), val_t'(1'b1));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_write", val_t'(mem_write), val_t'(1'b0));
    checkOutput("mid_rst_addr", val_t'(mem_address), val_t'(16'h0));
    checkOutput("mid_rst_wdata", mem_wdata, '0);
    clearInputs();
    tick();
    rst_n = 1'b1;
    tb_last_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("post_rst_read", val_t'(mem_read), val_t'(1'b0));
      checkOutput("post_rst_write", val_t'(mem_write), val_t'(1'b0));
      checkOutput("post_rst_resp", val_t'({i_pmem_resp, d_pmem_resp}), val_t'(2'b00));
    end

    // Randomized traffic against the transaction-level model
    m_busy = 1'b0; m_owner_d = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_last_d = 1'b1;
    m_addr = '0; m_wdata = '0;
    i_act = 1'b0; d_act = 1'b0; d_rd_r = 1'b0; d_wr_r = 1'b0;
    i_addr_r = '0; d_addr_r = '0; d_wdata_r = '0;
    mem_pend = 1'b0; mem_wait = 0; got_i = 1'b0; got_d = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      checkOutput("rnd_mem_read", val_t'(mem_read), val_t'(m_busy && m_rd));
      checkOutput("rnd_mem_write", val_t'(mem_write), val_t'(m_busy && m_wr));
      checkOutput("rnd_mem_address", val_t'(mem_address), val_t'(m_addr));
      if (m_busy && m_wr) checkOutput("rnd_mem_wdata", mem_wdata, m_wdata);

      if (got_i) i_act = 1'b0;
      if (got_d) d_act = 1'b0;
      if (!i_act && $urandom_range(0, 3) == 0) begin
        i_act    = 1'b1;
        i_addr_r = 16'($urandom);
      end else if (i_act && $urandom_range(0, 7) == 0) begin
        i_addr_r = 16'($urandom);
      end
      if (!d_act && $urandom_range(0, 3) == 0) begin
        int op;
        op        = int'($urandom_range(0, 2));
        d_act     = 1'b1;
        d_rd_r    = (op != 1);
        d_wr_r    = (op != 0);
        d_addr_r  = 16'($urandom);
        d_wdata_r = {$urandom, $urandom, $urandom, $urandom};
      end

      resp_now = 1'b0;
      if ((mem_read || mem_write) && !mem_pend) begin
        mem_pend = 1'b1;
        mem_wait = int'($urandom_range(0, 4));
      end
      if (mem_pend) begin
        if (mem_wait == 0) begin
          resp_now = 1'b1;
          mem_pend = 1'b0;
        end else begin
          mem_wait--;
        end
      end else if ($urandom_range(0, 9) == 0) begin
        resp_now = 1'b1;
      end
      rnd_rdata = {$urandom, $urandom, $urandom, $urandom};

      applyStimulus(i_act, i_addr_r, d_act && d_rd_r, d_act && d_wr_r,
                    d_addr_r, d_wdata_r, resp_now, rnd_rdata);

      got_i = m_busy && !m_owner_d && resp_now;
      got_d = m_busy && m_owner_d && resp_now;
      checkOutput("rnd_i_resp", val_t'(i_pmem_resp), val_t'(got_i));
      checkOutput("rnd_d_resp", val_t'(d_pmem_resp), val_t'(got_d));
      if (got_i) checkOutput("rnd_i_rdata", i_pmem_rdata, rnd_rdata);
      if (got_d) checkOutput("rnd_d_rdata", d_pmem_rdata, rnd_rdata);

      if (m_busy) begin
        if (resp_now) m_busy = 1'b0;
      end else if (i_act || d_act) begin
        if (i_act && d_act) pick_d = D_PRIORITY ? 1'b1 : !m_last_d;
        else pick_d = d_act;
        m_busy    = 1'b1;
        m_owner_d = pick_d;
        m_last_d  = pick_d;
        if (pick_d) begin
          m_addr  = d_addr_r;
          m_wdata = d_wdata_r;
          m_wr    = d_wr_r;
          m_rd    = !d_wr_r;
        end else begin
          m_addr  = i_addr_r;
          m_rd    = 1'b1;
          m_wr    = 1'b0;
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
